// File: rtl/lsu_pkg.sv
// Shared core constants: opcode/funct3 encodings, memory access size and LSU state enums,
// and the alignment rule used by the load/store unit.
package lsu_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [2:0] F3_B      = 3'b000;
  localparam logic [2:0] F3_H      = 3'b001;
  localparam logic [2:0] F3_W      = 3'b010;
  localparam logic [2:0] F3_D      = 3'b011;

  typedef enum logic [1:0] {
    SIZE_BYTE   = 2'd0,
    SIZE_HALF   = 2'd1,
    SIZE_WORD   = 2'd2,
    SIZE_DOUBLE = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  // An access is aligned when its address is a multiple of its size in bytes.
  function automatic logic is_misaligned(input logic [2:0] addr_lo, input mem_size_e size);
    case (size)
      SIZE_BYTE:   return 1'b0;
      SIZE_HALF:   return addr_lo[0] != 1'b0;
      SIZE_WORD:   return addr_lo[1:0] != 2'b00;
      SIZE_DOUBLE: return addr_lo != 3'b000;
      default:     return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load extraction: moves the addressed lanes of a bus word down to bit 0 and
// sign- or zero-extends them to the full data width.
module load_align
  import lsu_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [DWIDTH-1:0]            bus_rdata,
  input  logic [$clog2(DWIDTH/8)-1:0]  offset,
  input  mem_size_e                    size,
  input  logic                         is_unsigned,
  output logic [DWIDTH-1:0]            data
);

  logic [DWIDTH-1:0] shifted_s;
  logic              top_bit_s;
  int                nbits_s;

  // Shift, pick the field's sign bit, then extend above the field.
  always_comb begin
    shifted_s = bus_rdata >> {offset, 3'b000};
    case (size)
      SIZE_BYTE:   nbits_s = 8;
      SIZE_HALF:   nbits_s = 16;
      SIZE_WORD:   nbits_s = 32;
      SIZE_DOUBLE: nbits_s = 64;
      default:     nbits_s = 8;
    endcase
    if (nbits_s > DWIDTH) begin
      nbits_s = DWIDTH;
    end else begin
      nbits_s = nbits_s;
    end
    top_bit_s = 1'b0;
    for (int i = 0; i < DWIDTH; i++) begin
      top_bit_s = top_bit_s | (shifted_s[i] & (i == nbits_s - 1));
    end
    data = '0;
    for (int i = 0; i < DWIDTH; i++) begin
      data[i] = (i < nbits_s) ? shifted_s[i] : (top_bit_s & ~is_unsigned);
    end
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one core request at a time, drives a lane-encoded memory
// access with a bounded wait for mem_ack, and returns a single-cycle response.
module lsu
  import lsu_pkg::*;
#(
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [AWIDTH-1:0]   req_addr,
  input  logic [DWIDTH-1:0]   req_wdata,
  output logic                resp_valid,
  output logic [DWIDTH-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [AWIDTH-1:0]   mem_addr,
  output logic [DWIDTH/8-1:0] mem_be,
  output logic [DWIDTH-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DWIDTH-1:0]   mem_rdata
);

  localparam int BW   = DWIDTH / 8;
  localparam int OFFW = $clog2(BW);

  lsu_state_e        state_r, next_s;
  mem_size_e         req_size_s, size_r;
  logic [OFFW-1:0]   req_off_s, off_r;
  logic              uns_r;
  logic [7:0]        tmo_cnt_r;
  logic              accept_s, req_err_s, ack_s, tmo_hit_s;
  logic [7:0]        mask8_s;
  logic [15:0]       be_full_s;
  logic [BW-1:0]     be_s;
  logic [DWIDTH-1:0] wdata_s, load_data_s;
  logic [AWIDTH-1:0] maddr_s;

  assign req_size_s = mem_size_e'(req_size);
  assign req_off_s  = req_addr[OFFW-1:0];
  assign req_ready  = (state_r == ST_IDLE);
  assign accept_s   = req_valid && (state_r == ST_IDLE);
  assign req_err_s  = is_misaligned(req_addr[2:0], req_size_s) ||
                      ((req_size_s == SIZE_DOUBLE) && (DWIDTH == 32));
  assign ack_s      = (state_r == ST_ACCESS) && mem_ack;
  assign tmo_hit_s  = (state_r == ST_ACCESS) && !mem_ack && (tmo_cnt_r == 8'(TIMEOUT - 1));

  // Lane encoding of the incoming request, captured into the bus registers on acceptance.
  always_comb begin
    case (req_size_s)
      SIZE_BYTE:   mask8_s = 8'h01;
      SIZE_HALF:   mask8_s = 8'h03;
      SIZE_WORD:   mask8_s = 8'h0F;
      SIZE_DOUBLE: mask8_s = 8'hFF;
      default:     mask8_s = 8'h00;
    endcase
    be_full_s = {8'h00, mask8_s} << req_off_s;
    be_s      = be_full_s[BW-1:0];
    wdata_s   = req_wdata << {req_off_s, 3'b000};
    maddr_s   = {req_addr[AWIDTH-1:OFFW], {OFFW{1'b0}}};
  end

  // Next-state logic; an ack always beats a timeout on the same cycle.
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          next_s = req_err_s ? ST_RESP : ST_ACCESS;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (mem_ack || tmo_hit_s) begin
          next_s = ST_RESP;
        end else begin
          next_s = ST_ACCESS;
        end
      end
      ST_RESP: next_s = ST_IDLE;
      default: next_s = ST_IDLE;
    endcase
  end

  load_align #(.DWIDTH(DWIDTH)) u_load_align (
    .bus_rdata   (mem_rdata),
    .offset      (off_r),
    .size        (size_r),
    .is_unsigned (uns_r),
    .data        (load_data_s)
  );

  // State, bus and response registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      size_r     <= SIZE_BYTE;
      off_r      <= '0;
      uns_r      <= 1'b0;
      tmo_cnt_r  <= 8'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state_r    <= next_s;
      mem_req    <= (next_s == ST_ACCESS);
      resp_valid <= (next_s == ST_RESP);
      if (accept_s) begin
        size_r <= req_size_s;
        off_r  <= req_off_s;
        uns_r  <= req_unsigned;
      end
      if (accept_s && !req_err_s) begin
        mem_we    <= req_we;
        mem_addr  <= maddr_s;
        mem_be    <= be_s;
        mem_wdata <= wdata_s;
      end else if (next_s != ST_ACCESS) begin
        mem_we    <= 1'b0;
        mem_addr  <= '0;
        mem_be    <= '0;
        mem_wdata <= '0;
      end
      if ((state_r == ST_ACCESS) && (next_s == ST_ACCESS)) begin
        tmo_cnt_r <= tmo_cnt_r + 8'd1;
      end else begin
        tmo_cnt_r <= 8'd0;
      end
      if (accept_s && req_err_s) begin
        resp_err   <= 1'b1;
        resp_rdata <= '0;
      end else if (ack_s) begin
        resp_err   <= 1'b0;
        resp_rdata <= mem_we ? '0 : load_data_s;
      end else if (tmo_hit_s) begin
        resp_err   <= 1'b1;
        resp_rdata <= '0;
      end else if (state_r == ST_RESP) begin
        resp_err   <= 1'b0;
        resp_rdata <= '0;
      end
    end
  end

endmodule
